// File: rtl/stall_ctrl_pkg.sv
// Shared types and stall-vector constants for the pipeline stall controller.
package stall_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for perf counters.
module sat_counter
    import stall_ctrl_pkg::*;
#(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [PERF_W-1:0] cnt_o
);

    logic [PERF_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {PERF_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Central pipeline stall generator: merges stage stall requests with the
// shared-SRAM wait-state sequencer and counts stalled cycles.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int CNT_W           = 4,
    parameter int PERF_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    input  logic               memreq_i,
    input  logic               perf_clr_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               mem_busy_o,
    output logic [PERF_W-1:0]  stall_cycles_o
);

    localparam bit MULTI_CYCLE = (MEM_WAIT_CYCLES > 1);
    localparam logic [CNT_W-1:0] WCNT_RELOAD =
        MULTI_CYCLE ? CNT_W'(MEM_WAIT_CYCLES - 2) : '0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               mem_win;
    logic [STALL_W-1:0] stall_vec;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        mem_win = (state_q == ST_MEM_WAIT) || memreq_i;
        case (state_q)
            ST_IDLE: begin
                if (memreq_i && MULTI_CYCLE) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = WCNT_RELOAD;
                end
            end
            ST_MEM_WAIT: begin
                // A new access while waiting restarts the window from its start.
                if (memreq_i)
                    wcnt_d = WCNT_RELOAD;
                else if (wcnt_q == '0)
                    state_d = ST_IDLE;
                else
                    wcnt_d = wcnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Patterns are nested prefixes, so OR-ing them keeps the longest one.
    always_comb begin
        stall_vec = STALL_NONE;
        if (mem_win)       stall_vec = stall_vec | STALL_MEM;
        if (stallreq_id_i) stall_vec = stall_vec | STALL_ID;
        if (stallreq_ex_i) stall_vec = stall_vec | STALL_EX;
        if (rst == RST_ENABLE) stall_vec = STALL_NONE;
    end

    assign stall_o    = stall_vec;
    assign mem_busy_o = mem_win && (rst != RST_ENABLE);

    sat_counter #(
        .PERF_W(PERF_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_vec[0]),
        .clr_i (perf_clr_i),
        .cnt_o (stall_cycles_o)
    );

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized and directed bench for stall_ctrl against a window/prefix-length model.
module tb_stall_ctrl;

    localparam int MWC    = 2;
    localparam int CNT_W  = 4;
    localparam int PERF_W = 16;
    localparam int PMAX   = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_id_i, stallreq_ex_i, memreq_i, perf_clr_i;
    logic [5:0]        stall_o;
    logic              mem_busy_o;
    logic [PERF_W-1:0] stall_cycles_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model state: cycles of window still owed after the current one, perf count.
    int m_rem = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    stall_ctrl #(
        .MEM_WAIT_CYCLES(MWC),
        .CNT_W          (CNT_W),
        .PERF_W         (PERF_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_ex_i (stallreq_ex_i),
        .memreq_i      (memreq_i),
        .perf_clr_i    (perf_clr_i),
        .stall_o       (stall_o),
        .mem_busy_o    (mem_busy_o),
        .stall_cycles_o(stall_cycles_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs at negedge, advance model at posedge.
    task automatic cycle(input logic r, input logic id, input logic ex,
                         input logic mr, input logic clr);
        int len;
        logic win;
        logic [5:0] exp_stall;
        rst = r; stallreq_id_i = id; stallreq_ex_i = ex; memreq_i = mr; perf_clr_i = clr;
        @(negedge clk);
        win = r && (mr || (m_rem > 0));
        len = 0;
        if (r) begin
            if (win && len < 2) len = 2;
            if (id  && len < 3) len = 3;
            if (ex  && len < 4) len = 4;
        end
        exp_stall = 6'((1 << len) - 1);
        check("stall_o", 32'(stall_o), 32'(exp_stall));
        check("mem_busy_o", 32'(mem_busy_o), 32'(win));
        check("stall_cycles_o", 32'(stall_cycles_o), 32'(m_cnt));
        @(posedge clk);
        if (!r) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            if (clr)
                m_cnt = 0;
            else if (len > 0 && m_cnt < PMAX)
                m_cnt++;
            if (mr)
                m_rem = MWC - 1;
            else if (m_rem > 0)
                m_rem--;
        end
        #1;
    endtask

    initial begin
        // Reset then idle.
        cycle(0, 1, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
        // Single ID stall.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // Isolated memory access.
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // Back-to-back accesses with EX stall inside window.
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // ID and EX together.
        cycle(1, 1, 1, 0, 0);
        // Reset during MEM_WAIT.
        cycle(1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // Randomized traffic with rare resets and clears.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 199) == 0));
        end
        // Saturation of the perf counter, then clear.
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < PMAX + 6; i++) cycle(1, 1, 0, 0, 0);
        check("perf_saturated", 32'(stall_cycles_o), 32'(PMAX));
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        check("perf_cleared", 32'(stall_cycles_o), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
